// File: rtl/decode_uop_sequencer_pkg.sv
// Shared decode-pipeline types: pipeline stages, micro-op modes, sequencer states.
// The WB state exists only when DECODE_UOP_WRITEBACK_EN is defined.
package decode_uop_sequencer_pkg;

   typedef enum logic [1:0] {
      PIPE_FETCH,
      PIPE_DECODE,
      PIPE_EXECUTE,
      PIPE_WRITEBACK
   } pipe_stage_e;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      LDM    = 3'd1,
      STM    = 3'd2,
      PUSH   = 3'd3,
      POP    = 3'd4
   } uop_mode_e;

   // Byte distance between consecutive register slots in memory
   localparam int UOP_OFFSET = 4;

`ifdef DECODE_UOP_WRITEBACK_EN
   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      WB
   } seq_state_e;
`else
   typedef enum logic [0:0] {
      IDLE,
      EXPAND
   } seq_state_e;
`endif

   function automatic logic is_list_mode(input uop_mode_e mode);
      return (mode == LDM) || (mode == STM) || (mode == PUSH) || (mode == POP);
   endfunction

endpackage

// File: rtl/reg_list_priority_enc.sv
// Lowest-set-bit priority encoder for a register list.
module reg_list_priority_enc #(
   parameter int LIST_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic [LIST_W-1:0] list_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   // Scan from the top so the lowest set bit is the last one written
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = LIST_W - 1; k >= 0; k--) begin
         if (list_i[k]) begin
            idx_o   = IDX_W'(k);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decode_uop_sequencer.sv
// Expands SINGLE/LDM/STM/PUSH/POP instructions into per-register micro-ops.
// Define DECODE_UOP_WRITEBACK_EN to append a base-register writeback micro-op.
module decode_uop_sequencer
   import decode_uop_sequencer_pkg::*;
#(
   parameter int WORD       = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int REG_LIST_W = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  flush_i,
   input  logic                  instr_valid_i,
   output logic                  instr_ready_o,
   input  uop_mode_e             mode_i,
   input  logic [REG_LIST_W-1:0] reg_list_i,
   input  logic [ADDR_WIDTH-1:0] base_reg_i,
   input  logic [ADDR_WIDTH-1:0] single_reg_i,
   output logic                  uop_valid_o,
   input  logic                  uop_ready_i,
   output logic [ADDR_WIDTH-1:0] uop_reg_addr_o,
   output logic [ADDR_WIDTH-1:0] uop_base_addr_o,
   output logic [WORD-1:0]       uop_offset_o,
   output logic                  uop_is_load_o,
   output logic                  uop_is_wb_o,
   output logic                  uop_last_o
);

   seq_state_e            state_q;
   logic [REG_LIST_W-1:0] rem_q;
   logic [REG_LIST_W-1:0] enc_list;
   logic [REG_LIST_W-1:0] list_rest;
   logic [ADDR_WIDTH-1:0] enc_idx;
   logic                  enc_valid;
   logic [WORD-1:0]       list_count;
   logic [WORD-1:0]       list_span;
   logic [WORD-1:0]       first_offset;
   logic                  is_push;
   logic                  is_load_mode;
   logic                  accept;
   logic                  first_last;
   logic                  next_last;
`ifdef DECODE_UOP_WRITEBACK_EN
   logic                  wb_pend_q;
   logic [WORD-1:0]       wb_off_q;
   logic                  base_in_list;
   logic                  wb_apply;
`endif

   assign instr_ready_o = (state_q == IDLE) && !flush_i && (!uop_valid_o || uop_ready_i);
   assign accept        = instr_valid_i && instr_ready_o;

   // In IDLE the encoder looks at the incoming list, otherwise at what is left of it
   assign enc_list  = (state_q == IDLE) ? reg_list_i : rem_q;
   assign list_rest = enc_list & (enc_list - REG_LIST_W'(1));

   reg_list_priority_enc #(
      .LIST_W (REG_LIST_W),
      .IDX_W  (ADDR_WIDTH)
   ) u_enc (
      .list_i  (enc_list),
      .idx_o   (enc_idx),
      .valid_o (enc_valid)
   );

   always_comb begin
      list_count = '0;
      for (int k = 0; k < REG_LIST_W; k++) begin
         list_count = list_count + WORD'(reg_list_i[k]);
      end
   end

   assign list_span    = list_count * WORD'(UOP_OFFSET);
   assign is_push      = (mode_i == PUSH);
   assign is_load_mode = (mode_i == LDM) || (mode_i == POP);
   assign first_offset = is_push ? (WORD'(0) - list_span) : '0;

`ifdef DECODE_UOP_WRITEBACK_EN
   // An LDM that reloads its own base must not have that value clobbered by writeback
   always_comb begin
      base_in_list = 1'b0;
      for (int k = 0; k < REG_LIST_W; k++) begin
         if (ADDR_WIDTH'(k) == base_reg_i) begin
            base_in_list = reg_list_i[k];
         end
      end
   end

   assign wb_apply   = !((mode_i == LDM) && base_in_list);
   assign first_last = (list_rest == '0) && !wb_apply;
   assign next_last  = (list_rest == '0) && !wb_pend_q;
`else
   assign first_last = (list_rest == '0);
   assign next_last  = (list_rest == '0);
`endif

   // Sequencer state and registered micro-op outputs; flush beats accept and advance
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q         <= IDLE;
         rem_q           <= '0;
         uop_valid_o     <= 1'b0;
         uop_reg_addr_o  <= '0;
         uop_base_addr_o <= '0;
         uop_offset_o    <= '0;
         uop_is_load_o   <= 1'b0;
         uop_is_wb_o     <= 1'b0;
         uop_last_o      <= 1'b0;
`ifdef DECODE_UOP_WRITEBACK_EN
         wb_pend_q       <= 1'b0;
         wb_off_q        <= '0;
`endif
      end else if (flush_i) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         uop_valid_o <= 1'b0;
`ifdef DECODE_UOP_WRITEBACK_EN
         wb_pend_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (!is_list_mode(mode_i)) begin
                     uop_valid_o     <= 1'b1;
                     uop_reg_addr_o  <= single_reg_i;
                     uop_base_addr_o <= base_reg_i;
                     uop_offset_o    <= '0;
                     uop_is_load_o   <= 1'b0;
                     uop_is_wb_o     <= 1'b0;
                     uop_last_o      <= 1'b1;
                  end else if (enc_valid) begin
                     uop_valid_o     <= 1'b1;
                     uop_reg_addr_o  <= enc_idx;
                     uop_base_addr_o <= base_reg_i;
                     uop_offset_o    <= first_offset;
                     uop_is_load_o   <= is_load_mode;
                     uop_is_wb_o     <= 1'b0;
                     uop_last_o      <= first_last;
                     rem_q           <= list_rest;
                     state_q         <= EXPAND;
`ifdef DECODE_UOP_WRITEBACK_EN
                     wb_pend_q       <= wb_apply;
                     wb_off_q        <= is_push ? (WORD'(0) - list_span) : list_span;
`endif
                  end else begin
                     uop_valid_o <= 1'b0;
                  end
               end else if (uop_ready_i) begin
                  uop_valid_o <= 1'b0;
               end
            end
            EXPAND: begin
               if (uop_ready_i) begin
                  if (rem_q != '0) begin
                     uop_reg_addr_o <= enc_idx;
                     uop_offset_o   <= uop_offset_o + WORD'(UOP_OFFSET);
                     uop_last_o     <= next_last;
                     rem_q          <= list_rest;
`ifdef DECODE_UOP_WRITEBACK_EN
                  end else if (wb_pend_q) begin
                     uop_reg_addr_o <= uop_base_addr_o;
                     uop_offset_o   <= wb_off_q;
                     uop_is_wb_o    <= 1'b1;
                     uop_last_o     <= 1'b1;
                     wb_pend_q      <= 1'b0;
                     state_q        <= WB;
`endif
                  end else begin
                     uop_valid_o <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
`ifdef DECODE_UOP_WRITEBACK_EN
            WB: begin
               if (uop_ready_i) begin
                  uop_valid_o <= 1'b0;
                  uop_is_wb_o <= 1'b0;
                  state_q     <= IDLE;
               end
            end
`endif
            default: begin
               state_q     <= IDLE;
               uop_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
